pc_fetch: RTL and testbench

Instruction-fetch front end of the five-stage pipeline. It owns the program counter and drives the instruction ROM's chip-enable and byte address. It captures the ROM's combinational instruction word together with its PC into the IF/ID pipeline register for decode. The block handles sequential fetch, branch redirect, exception/flush redirect and pipeline stall.

---
 rtl/pc_fetch.sv | 137 +++++++++++++
 tb/tb_pc_fetch.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/pc_fetch.sv
`default_nettype none
// ============================================================================
// Module      : pc_fetch
// Description : Instruction-fetch front end of a five-stage pipeline. Owns
//               the program counter, drives the instruction ROM chip enable
//               and byte address, and registers the combinational ROM word
//               with its PC into the IF/ID pipeline register. Handles
//               sequential fetch, branch redirect, flush redirect and stall.
// Ports       : clk, rst            - clock, synchronous active-high reset
//               stall               - hold PC and IF/ID
//               branch_flag/_target - redirect request from decode
//               flush/new_pc        - exception/flush redirect request
//               pc, ce              - ROM byte address and chip enable
//               inst_i              - ROM instruction word (combinational)
//               id_pc, id_inst,
//               id_valid,
//               id_misalign         - IF/ID pipeline register contents
// Revision    : 1.0 - initial release
// ============================================================================
module pc_fetch #(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter bit          FLUSH_SQUASH = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        branch_flag,
    input  logic [31:0] branch_target,
    input  logic        flush,
    input  logic [31:0] new_pc,
    output logic [31:0] pc,
    output logic        ce,
    input  logic [31:0] inst_i,
    output logic [31:0] id_pc,
    output logic [31:0] id_inst,
    output logic        id_valid,
    output logic        id_misalign
);

    logic [31:0] pc_q,       pc_d;
    logic        ce_q,       ce_d;
    // Set by a redirect to a non-word-aligned target; consumed by the first
    // instruction captured from the redirected PC.
    logic        mis_pend_q, mis_pend_d;
    logic [31:0] id_pc_q,    id_pc_d;
    logic [31:0] id_inst_q,  id_inst_d;
    logic        id_valid_q, id_valid_d;
    logic        id_mis_q,   id_mis_d;

    // ------------------------------------------------------------------
    // Program counter / chip enable / misalign marker
    // ------------------------------------------------------------------
    always_comb begin
        pc_d       = pc_q;
        ce_d       = ce_q;
        mis_pend_d = mis_pend_q;

        if (!ce_q) begin
            // First edge out of reset only enables the ROM; pc stays put.
            ce_d = 1'b1;
        end else if (flush) begin
            pc_d       = {new_pc[31:2], 2'b00};
            mis_pend_d = |new_pc[1:0];
        end else if (stall) begin
            // Hold everything, including a pending misalign marker, so a
            // branch that arrives during a stall is simply ignored.
        end else if (branch_flag) begin
            pc_d       = {branch_target[31:2], 2'b00};
            mis_pend_d = |branch_target[1:0];
        end else begin
            // The word at pc_q is captured this edge and takes the marker.
            pc_d       = pc_q + 32'd4;
            mis_pend_d = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // IF/ID pipeline register
    // ------------------------------------------------------------------
    always_comb begin
        id_pc_d    = id_pc_q;
        id_inst_d  = id_inst_q;
        id_valid_d = id_valid_q;
        id_mis_d   = id_mis_q;

        if (flush && FLUSH_SQUASH) begin
            id_valid_d = 1'b0;
            id_inst_d  = 32'd0;
            id_mis_d   = 1'b0;
        end else if (flush || stall) begin
            // Non-squashing flush and stall both hold IF/ID.
        end else if (branch_flag) begin
            // Wrong-path word fetched this cycle is dropped (no delay slot).
            id_valid_d = 1'b0;
            id_inst_d  = 32'd0;
            id_mis_d   = 1'b0;
        end else if (ce_q) begin
            id_pc_d    = pc_q;
            id_inst_d  = inst_i;
            id_valid_d = 1'b1;
            id_mis_d   = mis_pend_q;
        end else begin
            id_valid_d = 1'b0;
            id_inst_d  = 32'd0;
            id_mis_d   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q       <= RESET_PC;
            ce_q       <= 1'b0;
            mis_pend_q <= 1'b0;
            id_pc_q    <= 32'd0;
            id_inst_q  <= 32'd0;
            id_valid_q <= 1'b0;
            id_mis_q   <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            ce_q       <= ce_d;
            mis_pend_q <= mis_pend_d;
            id_pc_q    <= id_pc_d;
            id_inst_q  <= id_inst_d;
            id_valid_q <= id_valid_d;
            id_mis_q   <= id_mis_d;
        end
    end

    assign pc          = pc_q;
    assign ce          = ce_q;
    assign id_pc       = id_pc_q;
    assign id_inst     = id_inst_q;
    assign id_valid    = id_valid_q;
    assign id_misalign = id_mis_q;

endmodule
`default_nettype wire

// File: tb/tb_pc_fetch.sv
`default_nettype none
// ============================================================================
// Module      : tb_pc_fetch
// Description : Self-checking bench for pc_fetch. A vector table of
//               per-edge stimulus and expected state is replayed through a
//               scoreboard queue; a hand-written sequence measures the
//               reset-release latency.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pc_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        branch_flag;
    logic [31:0] branch_target;
    logic        flush;
    logic [31:0] new_pc;
    logic [31:0] pc;
    logic        ce;
    logic [31:0] inst_i;
    logic [31:0] id_pc;
    logic [31:0] id_inst;
    logic        id_valid;
    logic        id_misalign;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    // Instruction ROM: distinct word per address.
    function automatic logic [31:0] rom(input logic [31:0] a);
        return (a * 32'h9E37_79B9) ^ 32'hA5A5_0F0F;
    endfunction

    assign inst_i = ce ? rom(pc) : 32'hDEAD_BEEF;

    pc_fetch #(
        .RESET_PC     (32'h0000_0000),
        .FLUSH_SQUASH (1'b1)
    ) u_dut (
        .clk           (clk),
        .rst           (rst),
        .stall         (stall),
        .branch_flag   (branch_flag),
        .branch_target (branch_target),
        .flush         (flush),
        .new_pc        (new_pc),
        .pc            (pc),
        .ce            (ce),
        .inst_i        (inst_i),
        .id_pc         (id_pc),
        .id_inst       (id_inst),
        .id_valid      (id_valid),
        .id_misalign   (id_misalign)
    );

    typedef struct {
        logic        rst;
        logic        stall;
        logic        br;
        logic [31:0] bt;
        logic        fl;
        logic [31:0] np;
        logic [31:0] e_pc;
        logic        e_ce;
        logic        e_iv;
        logic [31:0] e_ipc;   // checked only when e_iv=1
        logic        e_mis;
    } vec_t;

    typedef struct {
        int          idx;
        logic [31:0] e_pc;
        logic        e_ce;
        logic        e_iv;
        logic [31:0] e_ipc;
        logic [31:0] e_inst;
        logic        e_mis;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];

    task automatic add(input logic r, input logic s, input logic b, input logic [31:0] t,
                       input logic f, input logic [31:0] n, input logic [31:0] epc,
                       input logic ece, input logic eiv, input logic [31:0] eipc,
                       input logic emis);
        vec_t v;
        v.rst = r; v.stall = s; v.br = b; v.bt = t; v.fl = f; v.np = n;
        v.e_pc = epc; v.e_ce = ece; v.e_iv = eiv; v.e_ipc = eipc; v.e_mis = emis;
        vecs.push_back(v);
    endtask

    task automatic idle_inputs();
        rst = 1'b0; stall = 1'b0; branch_flag = 1'b0; branch_target = 32'd0;
        flush = 1'b0; new_pc = 32'd0;
    endtask

    initial begin
        exp_t e;
        int   edges;
        bit   seen;

        rst = 1'b1;
        stall = 1'b0; branch_flag = 1'b0; branch_target = 32'd0;
        flush = 1'b0; new_pc = 32'd0;

        //   rst stl br  target         fl  new_pc        pc             ce  iv  id_pc          mis
        add(1, 0, 0, 32'h0,         0, 32'h0,     32'h0,        0, 0, 32'h0,        0); // 0 reset
        add(1, 0, 0, 32'h0,         0, 32'h0,     32'h0,        0, 0, 32'h0,        0); // 1 reset
        add(0, 0, 0, 32'h0,         0, 32'h0,     32'h0,        1, 0, 32'h0,        0); // 2 ce rises
        add(0, 0, 0, 32'h0,         0, 32'h0,     32'h4,        1, 1, 32'h0,        0); // 3 A
        add(0, 0, 0, 32'h0,         0, 32'h0,     32'h8,        1, 1, 32'h4,        0); // 4 B
        add(0, 0, 0, 32'h0,         0, 32'h0,     32'hC,        1, 1, 32'h8,        0); // 5 C
        add(0, 0, 0, 32'h0,         0, 32'h0,     32'h10,       1, 1, 32'hC,        0); // 6 D
        add(0, 1, 0, 32'h0,         0, 32'h0,     32'h10,       1, 1, 32'hC,        0); // 7 stall
        add(0, 1, 0, 32'h0,         0, 32'h0,     32'h10,       1, 1, 32'hC,        0); // 8 stall
        add(0, 1, 0, 32'h0,         0, 32'h0,     32'h10,       1, 1, 32'hC,        0); // 9 stall
        add(0, 0, 0, 32'h0,         0, 32'h0,     32'h14,       1, 1, 32'h10,       0); // 10 resume
        add(0, 0, 0, 32'h0,         0, 32'h0,     32'h18,       1, 1, 32'h14,       0); // 11
        add(0, 0, 1, 32'h40,        0, 32'h0,     32'h40,       1, 0, 32'h0,        0); // 12 branch
        add(0, 0, 0, 32'h0,         0, 32'h0,     32'h44,       1, 1, 32'h40,       0); // 13 target
        add(0, 1, 1, 32'h100,       0, 32'h0,     32'h44,       1, 1, 32'h40,       0); // 14 br+stall
        add(0, 0, 1, 32'h100,       0, 32'h0,     32'h100,      1, 0, 32'h0,        0); // 15 branch
        add(0, 0, 0, 32'h0,         0, 32'h0,     32'h104,      1, 1, 32'h100,      0); // 16
        add(0, 1, 1, 32'h40,        1, 32'h80,    32'h80,       1, 0, 32'h0,        0); // 17 fl+st+br
        add(0, 0, 0, 32'h0,         0, 32'h0,     32'h84,       1, 1, 32'h80,       0); // 18
        add(0, 1, 1, 32'h40,        1, 32'h82,    32'h80,       1, 0, 32'h0,        0); // 19 misaligned flush
        add(0, 0, 0, 32'h0,         0, 32'h0,     32'h84,       1, 1, 32'h80,       1); // 20 marked
        add(0, 0, 0, 32'h0,         0, 32'h0,     32'h88,       1, 1, 32'h84,       0); // 21 unmarked
        add(0, 0, 1, 32'h203,       0, 32'h0,     32'h200,      1, 0, 32'h0,        0); // 22 misaligned br
        add(0, 1, 0, 32'h0,         0, 32'h0,     32'h200,      1, 0, 32'h0,        0); // 23 stall in bubble
        add(0, 0, 0, 32'h0,         0, 32'h0,     32'h204,      1, 1, 32'h200,      1); // 24 marked
        add(0, 0, 0, 32'h0,         0, 32'h0,     32'h208,      1, 1, 32'h204,      0); // 25
        add(0, 0, 1, 32'hFFFF_FFFC, 0, 32'h0,     32'hFFFF_FFFC, 1, 0, 32'h0,       0); // 26 to top
        add(0, 0, 0, 32'h0,         0, 32'h0,     32'h0,        1, 1, 32'hFFFF_FFFC, 0); // 27 wrap
        add(0, 0, 0, 32'h0,         0, 32'h0,     32'h4,        1, 1, 32'h0,        0); // 28
        add(1, 0, 0, 32'h0,         0, 32'h0,     32'h0,        0, 0, 32'h0,        0); // 29 mid reset
        add(0, 0, 0, 32'h0,         0, 32'h0,     32'h0,        1, 0, 32'h0,        0); // 30 ce rises
        add(0, 0, 0, 32'h0,         0, 32'h0,     32'h4,        1, 1, 32'h0,        0); // 31
        add(0, 0, 0, 32'h0,         0, 32'h0,     32'h8,        1, 1, 32'h4,        0); // 32

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            rst = vecs[i].rst; stall = vecs[i].stall;
            branch_flag = vecs[i].br; branch_target = vecs[i].bt;
            flush = vecs[i].fl; new_pc = vecs[i].np;
            e.idx    = i;
            e.e_pc   = vecs[i].e_pc;
            e.e_ce   = vecs[i].e_ce;
            e.e_iv   = vecs[i].e_iv;
            e.e_ipc  = vecs[i].e_ipc;
            e.e_inst = vecs[i].e_iv ? rom(vecs[i].e_ipc) : 32'd0;
            e.e_mis  = vecs[i].e_mis;
            sb.push_back(e);

            @(posedge clk);
            #1;
            e = sb.pop_front();
            n_tests++;
            if (pc !== e.e_pc || ce !== e.e_ce || id_valid !== e.e_iv ||
                id_inst !== e.e_inst || id_misalign !== e.e_mis ||
                (e.e_iv && id_pc !== e.e_ipc)) begin
                n_fail++;
                $display("FAIL vec%0d: got pc=%h ce=%b iv=%b id_pc=%h inst=%h mis=%b; want pc=%h ce=%b iv=%b id_pc=%h inst=%h mis=%b",
                         e.idx, pc, ce, id_valid, id_pc, id_inst, id_misalign,
                         e.e_pc, e.e_ce, e.e_iv, e.e_ipc, e.e_inst, e.e_mis);
            end
        end

        // Reset-release latency: first id_valid must appear on the 2nd edge.
        @(negedge clk);
        idle_inputs();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        edges = 0;
        seen  = 1'b0;
        while (!seen && edges < 8) begin
            @(posedge clk);
            #1;
            edges++;
            if (id_valid === 1'b1) seen = 1'b1;
        end
        n_tests++;
        if (!seen || edges != 2) begin
            n_fail++;
            $display("FAIL reset_latency: got seen=%b edges=%0d; want seen=1 edges=2", seen, edges);
        end
        n_tests++;
        if (id_pc !== 32'h0 || id_inst !== rom(32'h0)) begin
            n_fail++;
            $display("FAIL reset_first_inst: got id_pc=%h inst=%h; want id_pc=%h inst=%h",
                     id_pc, id_inst, 32'h0, rom(32'h0));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
